// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// status/interrupt bit positions, cause codes and the sequencing states.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MSIP_BIT = 3;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI     = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;

  typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIR} trap_state_e;

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector feeding a sticky pending flag; a new edge beats a
// same-cycle clear so no interrupt is lost.
module irq_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pending
);

  logic irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      irq_q <= irq;
      if (irq && !irq_q) pending <= 1'b1;
      else if (clr)      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt controller: owns the trap CSRs, picks traps at
// instruction boundaries and sequences flush -> redirect for traps and mret.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interupt,
  input  logic            mtip_i,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            ecall_i,
  input  logic            illegal_i,
  input  logic            mret_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ack_i
);

  trap_state_e     state, state_next;
  logic            st_mie, st_mpie, msip, meip;
  logic [XLEN-1:0] mie_r, mtvec, mepc, mcause;
  logic [XLEN-1:0] mip, pend, cause, trap_tgt, base;
  logic            exc, is_irq, sel_mei, take_trap, take_mret;

  always_comb begin
    mip           = '0;
    mip[MSIP_BIT] = msip;
    mip[MTIP_BIT] = mtip_i;
    mip[MEIP_BIT] = meip;
  end

  assign pend = st_mie ? (mip & mie_r) : '0;
  assign exc  = illegal_i | ecall_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cause   = '0;
    is_irq  = 1'b0;
    sel_mei = 1'b0;
    if (illegal_i)           cause = XLEN'(CAUSE_ILLEGAL);
    else if (ecall_i)        cause = XLEN'(CAUSE_ECALL);
    else if (pend[MEIP_BIT]) begin cause = XLEN'(CAUSE_MEI); is_irq = 1'b1; sel_mei = 1'b1; end
    else if (pend[MSIP_BIT]) begin cause = XLEN'(CAUSE_MSI); is_irq = 1'b1; end
    else if (pend[MTIP_BIT]) begin cause = XLEN'(CAUSE_MTI); is_irq = 1'b1; end
  end

  assign take_trap = (state == IDLE) && commit_valid_i && (exc || is_irq);
  assign take_mret = (state == IDLE) && commit_valid_i && mret_i && !exc && !is_irq;

  irq_edge_latch u_meip (
    .clk     (clk),
    .rst     (rst),
    .irq     (interupt),
    .clr     (take_trap && sel_mei),
    .pending (meip)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next       = state;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (take_trap)      state_next = TRAP;
        else if (take_mret) state_next = MRET;
      end
      TRAP, MRET: begin
        flush_o    = 1'b1;
        state_next = REDIR;
      end
      REDIR: begin
        redirect_valid_o = 1'b1;
        if (redirect_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Vectored mode only applies to interrupts; mcause already holds the new cause in TRAP.
  assign base     = {mtvec[XLEN-1:2], 2'b00};
  assign trap_tgt = (mtvec[1:0] == 2'b01 && mcause[XLEN-1]) ?
                    base + XLEN'({mcause[4:0], 2'b00}) : base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                redirect_pc_o <= '0;
    else if (state == TRAP)  redirect_pc_o <= trap_tgt;
    else if (state == MRET)  redirect_pc_o <= mepc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      msip    <= 1'b0;
      mie_r   <= '0;
      mtvec   <= RESET_MTVEC;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      if (csr_we_i) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            st_mie  <= csr_wdata_i[MIE_BIT];
            st_mpie <= csr_wdata_i[MPIE_BIT];
          end
          CSR_MIE:    mie_r  <= csr_wdata_i;
          CSR_MTVEC:  mtvec  <= csr_wdata_i;
          CSR_MEPC:   mepc   <= {csr_wdata_i[XLEN-1:2], 2'b00};
          CSR_MCAUSE: mcause <= csr_wdata_i;
          CSR_MIP:    msip   <= csr_wdata_i[MSIP_BIT];
          default: ;
        endcase
      end
      // NOTE: with non-blocking assignments the last one in the block wins, which gives trap/mret updates priority over a same-cycle CSR write.
      if (take_trap) begin
        mepc    <= is_irq ? {next_pc_i[XLEN-1:2], 2'b00}
                          : ((next_pc_i - XLEN'(4)) & ~XLEN'(3));
        mcause  <= cause;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (take_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MIE_BIT]  = st_mie;
        csr_rdata_o[MPIE_BIT] = st_mpie;
      end
      CSR_MIE:    csr_rdata_o = mie_r;
      CSR_MTVEC:  csr_rdata_o = mtvec;
      CSR_MEPC:   csr_rdata_o = mepc;
      CSR_MCAUSE: csr_rdata_o = mcause;
      CSR_MIP:    csr_rdata_o = mip;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: expected redirect targets are queued when
// a commit is driven and compared when the controller raises its redirect.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        interupt = 1'b0, mtip_i = 1'b0, commit_valid_i = 1'b0;
  logic [31:0] next_pc_i = '0;
  logic        ecall_i = 1'b0, illegal_i = 1'b0, mret_i = 1'b0;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [31:0] csr_rdata_o;
  logic        flush_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ack_i = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .interupt         (interupt),
    .mtip_i           (mtip_i),
    .commit_valid_i   (commit_valid_i),
    .next_pc_i        (next_pc_i),
    .ecall_i          (ecall_i),
    .illegal_i        (illegal_i),
    .mret_i           (mret_i),
    .csr_we_i         (csr_we_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_rdata_o      (csr_rdata_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ack_i   (redirect_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    csr_we_i = 1'b1; csr_addr_i = addr; csr_wdata_i = data;
    @(negedge clk);
    csr_we_i = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] addr, input logic [31:0] expected);
    csr_addr_i = addr;
    #1;
    check(tag, csr_rdata_o, expected);
  endtask

  task automatic pulse_irq();
    @(negedge clk); interupt = 1'b1;
    @(negedge clk); interupt = 1'b0;
  endtask

  task automatic wait_redirect(input int ack_delay);
    logic [31:0] exp_pc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (redirect_valid_o) break;
    end
    check("redirect_seen", {31'b0, redirect_valid_o}, 32'd1);
    if (!redirect_valid_o) return;
    check("flush_one_cycle", {31'b0, flush_o}, 32'd0);
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("redirect_pc", redirect_pc_o, exp_pc);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk); #1;
      check("hold_valid", {31'b0, redirect_valid_o}, 32'd1);
      check("hold_pc", redirect_pc_o, exp_pc);
    end
    redirect_ack_i = 1'b1;
    @(negedge clk);
    redirect_ack_i = 1'b0;
    #1;
    check("redirect_done", {31'b0, redirect_valid_o}, 32'd0);
  endtask

  task automatic run_commit(input logic [31:0] pc, input logic ec, input logic il,
                            input logic mr, input logic [31:0] exp_tgt, input int ack_delay);
    @(negedge clk);
    next_pc_i = pc; ecall_i = ec; illegal_i = il; mret_i = mr; commit_valid_i = 1'b1;
    exp_q.push_back(exp_tgt);
    @(negedge clk);
    commit_valid_i = 1'b0; ecall_i = 1'b0; illegal_i = 1'b0; mret_i = 1'b0; csr_we_i = 1'b0;
    #1;
    check("flush_set", {31'b0, flush_o}, 32'd1);
    check("no_early_redirect", {31'b0, redirect_valid_o}, 32'd0);
    wait_redirect(ack_delay);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with stimulus toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      interupt       = 1'($urandom_range(0, 1));
      commit_valid_i = 1'($urandom_range(0, 1));
      illegal_i      = 1'($urandom_range(0, 1));
      csr_we_i       = 1'($urandom_range(0, 1));
      csr_addr_i     = CSR_MSTATUS;
      csr_wdata_i    = $urandom;
      #1;
      check("rst_flush", {31'b0, flush_o}, 32'd0);
      check("rst_redir_valid", {31'b0, redirect_valid_o}, 32'd0);
      check("rst_redir_pc", redirect_pc_o, 32'd0);
    end
    interupt = 1'b0; commit_valid_i = 1'b0; illegal_i = 1'b0; csr_we_i = 1'b0;
    csr_chk("rst_mtvec", CSR_MTVEC, 32'h100);
    csr_chk("rst_mstatus", CSR_MSTATUS, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    csr_chk("rst_mip", CSR_MIP, 32'h0);
    csr_chk("rst_mcause", CSR_MCAUSE, 32'h0);

    // External interrupt, direct mode
    csr_wr(CSR_MSTATUS, 32'h8);
    csr_wr(CSR_MIE, 32'h800);
    pulse_irq();
    csr_chk("meip_latched", CSR_MIP, 32'h800);
    run_commit(32'h40, 1'b0, 1'b0, 1'b0, 32'h100, 0);
    csr_chk("mei_mepc", CSR_MEPC, 32'h40);
    csr_chk("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_chk("mei_mstatus", CSR_MSTATUS, 32'h80);
    csr_chk("mei_cleared", CSR_MIP, 32'h0);

    // Timer interrupt, vectored mode, slow ack
    csr_wr(CSR_MTVEC, 32'h101);
    csr_wr(CSR_MIE, 32'h80);
    csr_wr(CSR_MSTATUS, 32'h8);
    mtip_i = 1'b1;
    run_commit(32'h200, 1'b0, 1'b0, 1'b0, 32'h11C, 3);
    mtip_i = 1'b0;
    csr_chk("mti_mcause", CSR_MCAUSE, 32'h8000_0007);
    csr_chk("mti_mepc", CSR_MEPC, 32'h200);

    // Illegal beats pending MEI; MEI taken after mret
    csr_wr(CSR_MIE, 32'h800);
    csr_wr(CSR_MSTATUS, 32'h8);
    pulse_irq();
    run_commit(32'h24, 1'b0, 1'b1, 1'b0, 32'h100, 0);
    csr_chk("ill_mcause", CSR_MCAUSE, 32'h2);
    csr_chk("ill_mepc", CSR_MEPC, 32'h20);
    csr_chk("ill_meip_kept", CSR_MIP, 32'h800);
    run_commit(32'h30, 1'b0, 1'b0, 1'b1, 32'h20, 0);
    csr_chk("mret1_mstatus", CSR_MSTATUS, 32'h88);
    run_commit(32'h24, 1'b0, 1'b0, 1'b0, 32'h12C, 1);
    csr_chk("mei2_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_chk("mei2_mepc", CSR_MEPC, 32'h24);
    csr_chk("mei2_mip", CSR_MIP, 32'h0);

    // mret to mepc 0x40 with MPIE=1; mepc low bits and unimplemented CSR
    csr_wr(CSR_MSTATUS, 32'h80);
    csr_wr(CSR_MEPC, 32'h43);
    csr_chk("mepc_align", CSR_MEPC, 32'h40);
    csr_wr(12'h340, 32'h1234_5678);
    csr_chk("unimpl_read", 12'h340, 32'h0);
    run_commit(32'h99, 1'b0, 1'b0, 1'b1, 32'h40, 0);
    csr_chk("mret2_mstatus", CSR_MSTATUS, 32'h88);

    // ecall while a CSR write to mcause is active: trap update wins
    csr_we_i = 1'b1; csr_addr_i = CSR_MCAUSE; csr_wdata_i = 32'h55;
    run_commit(32'h84, 1'b1, 1'b0, 1'b0, 32'h100, 0);
    csr_chk("ecall_mcause", CSR_MCAUSE, 32'hB);
    csr_chk("ecall_mepc", CSR_MEPC, 32'h80);
    csr_chk("ecall_mstatus", CSR_MSTATUS, 32'h80);

    // Reset asserted during REDIR
    @(negedge clk);
    next_pc_i = 32'h90; ecall_i = 1'b1; commit_valid_i = 1'b1;
    @(negedge clk);
    ecall_i = 1'b0; commit_valid_i = 1'b0;
    @(negedge clk); #1;
    check("pre_rst_redir", {31'b0, redirect_valid_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, redirect_valid_o}, 32'd0);
    check("async_rst_pc", redirect_pc_o, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_valid", {31'b0, redirect_valid_o}, 32'd0);
    check("post_rst_flush", {31'b0, flush_o}, 32'd0);
    csr_chk("post_rst_mtvec", CSR_MTVEC, 32'h100);
    csr_chk("post_rst_mcause", CSR_MCAUSE, 32'h0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap and interrupt controller for the single-issue RV32I core. It owns the trap CSRs and decides at each instruction boundary whether to take an exception or an interrupt. When it takes one, it sequences the datapath through a pipeline flush, saves state and redirects the PC. It sits beside the CSR file and receives the core-level interupt pin and datapath commit information.

Parameters:
XLEN, 32, data/address width
RESET_MTVEC, 32'h0000_0100, reset value of mtvec

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous and active-low (asserted when 0)
interupt  in  1  external interrupt; pulse or level, rising edge latched
mtip_i  in  1  timer interrupt, level
commit_valid_i  in  1  instruction retiring this cycle (trap boundary)
next_pc_i  in  XLEN  PC of the next instruction to execute after the retiring one
ecall_i  in  1  retiring instruction is ecall
illegal_i  in  1  retiring instruction is illegal
mret_i  in  1  retiring instruction is mret
csr_we_i  in  1  CSR write strobe from the datapath
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  CSR write data (already resolved csrrw/s/c)
csr_rdata_o  out  XLEN  combinational CSR read data
flush_o  out  1  kill all younger in-flight instructions
redirect_valid_o  out  1  PC redirect request
redirect_pc_o  out  XLEN  redirect target
redirect_ack_i  in  1  fetch accepted the redirect

Behaviour:
- Owned CSRs: mstatus (0x300: MIE bit 3, MPIE bit 7), mie (0x304), mtvec (0x305), mepc (0x341), mcause (0x342), mip (0x344: MSIP bit 3 writable; MTIP bit 7 = mtip_i; MEIP bit 11 = latched interupt).
- Reset values: all CSRs 0 except mtvec = RESET_MTVEC; FSM = IDLE; flush_o = 0; redirect_valid_o = 0; redirect_pc_o = 0.
- Unimplemented CSR address: read 0, write ignored. mepc[1:0] always reads 0.
- MEIP latch: set on a rising edge of interupt (one-flop edge detect). Cleared when the external interrupt trap is taken. A set event in the same cycle as a clear wins.
- Pending interrupt = mip & mie, gated by mstatus.MIE.
- Priority: illegal (cause 2) > ecall (cause 11) > MEI (0x8000_000B) > MSI (0x8000_0003) > MTI (0x8000_0007).
- States: IDLE, TRAP, MRET, REDIR.
- IDLE -> TRAP on commit_valid_i when any exception is flagged or any interrupt is pending.
  - In TRAP (1 cycle): flush_o = 1.
  - mepc <= next_pc_i for interrupts; mepc <= PC of the faulting instruction (next_pc_i - 4) for exceptions.
  - mcause <= cause; MPIE <= MIE; MIE <= 0.
  - Next state is REDIR with target from mtvec.
- Trap target: mtvec[1:0] = 00 gives base (mtvec & ~3). 01 gives base + 4*cause[4:0] for interrupts and base for exceptions.
- IDLE -> MRET on commit_valid_i & mret_i with no exception.
  - In MRET (1 cycle): flush_o = 1; MIE <= MPIE; MPIE <= 1; target = mepc.
  - Next state is REDIR.
- REDIR: redirect_valid_o = 1 and redirect_pc_o stable until redirect_ack_i, then IDLE.
  - Ack in the first REDIR cycle is allowed, giving a 2-cycle trap/mret sequence.
- No new trap is evaluated outside IDLE. Interrupts arriving in TRAP, MRET or REDIR stay pending. MIE = 0 after trap entry blocks nesting.
- CSR write and trap in the same cycle: the trap-side update of mstatus, mepc and mcause wins; writes to other CSRs take effect.
- Reset mid-sequence: all state returns to reset values asynchronously and no redirect is issued.

Decomposition:
- trap_pkg holds:
  - CSR address localparams;
  - bit positions MIE=3, MPIE=7, MSIP=3, MTIP=7, MEIP=11;
  - cause codes;
  - state enum trap_state_e {IDLE, TRAP, MRET, REDIR}.
- One sub-module, irq_edge_latch: the edge detect plus sticky MEIP with set and clear.

Test Plan:
- Reset: hold rst = 0 with stimulus toggling -> all outputs 0, mtvec reads 0x100, mstatus reads 0.
- Write mstatus = 0x8 and mie = 0x800, pulse interupt for 1 cycle, commit with next_pc = 0x40 -> flush_o for 1 cycle, then redirect_pc = 0x100, mepc = 0x40, mcause = 0x8000_000B, mstatus = 0x80, MEIP cleared.
- Set mtvec = 0x101 (vectored), enable MTI, drive mtip_i = 1 -> redirect_pc = 0x11C; with redirect_ack_i held low for 3 cycles, redirect_valid and redirect_pc stay stable.
- With illegal_i and a pending MEI in the same commit, next_pc = 0x24 -> mcause = 2, mepc = 0x20, MEIP stays set; after mret, MEI is taken next.
- mret with mepc = 0x40 and MPIE = 1 -> flush, redirect_pc = 0x40, mstatus = 0x88.
- Assert rst in the REDIR state -> redirect_valid_o drops immediately and FSM = IDLE after release.
